// File: rtl/prior_arbiter_n_pkg.sv
// rtl/prior_arbiter_n_pkg.sv - shared state and mode encodings for the priority arbiter
package prior_arbiter_n_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/prior_arbiter_n_find.sv
// rtl/prior_arbiter_n_find.sv - combinational highest-set-bit finder
module prio_find_n #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan: the last hit, i.e. the highest set bit, wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prior_arbiter_n.sv
// rtl/prior_arbiter_n.sv - registered N-input fixed-priority / round-robin arbiter
module prior_arbiter_n
  import prior_arbiter_n_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         ack,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic [N-1:0] onehot
);

  logic         state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;

  logic         ack_fire;
  logic [W-1:0] win_idx;
  logic         win_any;
  logic [N-1:0] win_onehot;

  assign ack_fire = (state_q == ST_GRANT) && ack;

  if (MODE == MODE_RR) begin : g_rr
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_eff;
    logic [N-1:0] mask;
    logic [N-1:0] req_masked;
    logic [W-1:0] m_idx, u_idx;
    logic         m_any, u_any;

    // A back-to-back grant must already see the pointer at the acked index.
    assign ptr_eff = ack_fire ? idx_q : ptr_q;

    always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
        mask[i] = (W'(i) < ptr_eff);
      end
    end

    assign req_masked = req & mask;

    prio_find_n #(.N(N)) u_find_masked (
      .vec_i (req_masked),
      .idx_o (m_idx),
      .any_o (m_any)
    );

    prio_find_n #(.N(N)) u_find_full (
      .vec_i (req),
      .idx_o (u_idx),
      .any_o (u_any)
    );

    assign win_idx = m_any ? m_idx : u_idx;
    assign win_any = u_any;

    always_ff @(posedge clk) begin
      if (reset) begin
        ptr_q <= '0;
      end else if (ack_fire) begin
        ptr_q <= idx_q;
      end
    end
  end else begin : g_fixed
    prio_find_n #(.N(N)) u_find (
      .vec_i (req),
      .idx_o (win_idx),
      .any_o (win_any)
    );
  end

  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (state_q == ST_IDLE) begin
      if (en && win_any) begin
        state_d  = ST_GRANT;
        idx_d    = win_idx;
        onehot_d = win_onehot;
      end
    end else if (ack) begin
      if (en && win_any) begin
        idx_d    = win_idx;
        onehot_d = win_onehot;
      end else begin
        state_d  = ST_IDLE;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign idx    = idx_q;
  assign valid  = (state_q == ST_GRANT);
  assign onehot = onehot_q;

endmodule

// File: tb/tb_prior_arbiter_n.sv
// tb/tb_prior_arbiter_n.sv - directed self-checking bench for prior_arbiter_n
module tb_prior_arbiter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       en;
  logic       ack;

  logic [2:0] fx_idx, rr_idx;
  logic       fx_valid, rr_valid;
  logic [7:0] fx_onehot, rr_onehot;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  prior_arbiter_n #(.N(8), .MODE(0)) dut_fx (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .en     (en),
    .ack    (ack),
    .idx    (fx_idx),
    .valid  (fx_valid),
    .onehot (fx_onehot)
  );

  prior_arbiter_n #(.N(8), .MODE(1)) dut_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .en     (en),
    .ack    (ack),
    .idx    (rr_idx),
    .valid  (rr_valid),
    .onehot (rr_onehot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rot [14] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4, 3, 2};

    reset = 1'b1; req = 8'hFF; en = 1'b1; ack = 1'b0;
    tick(); tick();
    chk("rst_fx_valid", 32'(fx_valid), 32'd0);
    chk("rst_fx_idx", 32'(fx_idx), 32'd0);
    chk("rst_fx_onehot", 32'(fx_onehot), 32'h00);
    chk("rst_rr_valid", 32'(rr_valid), 32'd0);
    chk("rst_rr_onehot", 32'(rr_onehot), 32'h00);

    reset = 1'b0; en = 1'b0;
    tick(); tick();
    chk("idle_en0_fx", 32'(fx_valid), 32'd0);
    chk("idle_en0_rr", 32'(rr_valid), 32'd0);

    ack = 1'b1;
    tick();
    chk("ack_idle_no_effect", 32'(fx_valid), 32'd0);

    ack = 1'b0; en = 1'b1; req = 8'b0010_0110;
    tick();
    chk("fx_first_valid", 32'(fx_valid), 32'd1);
    chk("fx_first_idx", 32'(fx_idx), 32'd5);
    chk("fx_first_onehot", 32'(fx_onehot), 32'h20);
    chk("rr_first_idx", 32'(rr_idx), 32'd5);

    req = 8'h01;
    tick();
    chk("fx_hold_idx", 32'(fx_idx), 32'd5);
    chk("fx_hold_valid", 32'(fx_valid), 32'd1);
    chk("rr_hold_idx", 32'(rr_idx), 32'd5);

    ack = 1'b1; req = 8'h00;
    tick();
    chk("rel_fx_valid", 32'(fx_valid), 32'd0);
    chk("rel_fx_onehot", 32'(fx_onehot), 32'h00);
    chk("rel_fx_idx_kept", 32'(fx_idx), 32'd5);
    chk("rel_rr_valid", 32'(rr_valid), 32'd0);

    ack = 1'b0; req = 8'h08;
    tick();
    chk("regrant_fx_idx", 32'(fx_idx), 32'd3);
    chk("regrant_fx_valid", 32'(fx_valid), 32'd1);
    chk("regrant_rr_idx", 32'(rr_idx), 32'd3);

    reset = 1'b1;
    tick();
    chk("rst2_rr_valid", 32'(rr_valid), 32'd0);

    reset = 1'b0; req = 8'hFF; en = 1'b1; ack = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("rot_rr_idx_%0d", i), 32'(rr_idx), 32'(rot[i]));
      chk($sformatf("rot_rr_valid_%0d", i), 32'(rr_valid), 32'd1);
      chk($sformatf("rot_fx_idx_%0d", i), 32'(fx_idx), 32'd7);
    end
    chk("rot_rr_onehot_2", 32'(rr_onehot), 32'h04);

    req = 8'b1000_0100;
    tick();
    chk("wrap_rr_idx", 32'(rr_idx), 32'd7);
    chk("wrap_rr_onehot", 32'(rr_onehot), 32'h80);

    req = 8'hFF;
    tick();
    chk("pre_rst_rr_idx", 32'(rr_idx), 32'd6);

    reset = 1'b1;
    tick();
    chk("midrst_rr_valid", 32'(rr_valid), 32'd0);
    chk("midrst_rr_idx", 32'(rr_idx), 32'd0);
    chk("midrst_rr_onehot", 32'(rr_onehot), 32'h00);

    reset = 1'b0; ack = 1'b0;
    tick();
    chk("post_rst_rr_idx", 32'(rr_idx), 32'd7);
    chk("post_rst_fx_onehot", 32'(fx_onehot), 32'h80);

    en = 1'b0; ack = 1'b1;
    tick();
    chk("en0_ack_rr_valid", 32'(rr_valid), 32'd0);
    chk("en0_ack_fx_valid", 32'(fx_valid), 32'd0);
    tick();
    chk("en0_stay_idle", 32'(rr_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
